// File: rtl/hdlc_pkg.sv
// Shared HDLC definitions: sequencer state encoding and CRC-CCITT constants.
package hdlc_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DATA   = 3'd1,
    S_FCS_LO = 3'd2,
    S_FCS_HI = 3'd3,
    S_ABT    = 3'd4
  } state_t;

  localparam logic [15:0] CRC_INIT        = 16'hFFFF;
  localparam logic [15:0] CRC_RESIDUE     = 16'hF0B8;
  localparam logic [7:0]  HDLC_ABORT_BYTE = 8'h00;

endpackage

// File: rtl/crc16_8.sv
// Byte-wide CRC-CCITT engine (reflected, poly 0x8408), one byte per enabled clock.
module crc16_8
  import hdlc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  d,
  input  logic        en,
  input  logic        crc_rst,
  output logic [15:0] crc_inv,
  output logic        crc_ok
);

  logic [15:0] crc;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 16'h8408;
      else             r = r >> 1;
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        crc <= CRC_INIT;
    else if (crc_rst) crc <= CRC_INIT;
    else if (en)      crc <= crc_step(crc, d);
  end

  assign crc_inv = ~crc;
  // Running a whole frame plus its FCS through the engine leaves the fixed residue.
  assign crc_ok  = (crc == CRC_RESIDUE);

endmodule

// File: rtl/hdlc_fcs_sequencer.sv
// HDLC transmit sequencer: forwards payload bytes, appends the 2-byte FCS, handles abort/oversize.
module hdlc_fcs_sequencer
  import hdlc_pkg::*;
#(
  parameter int MAX_LEN = 1024,
  parameter int LEN_W   = 11,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  input  logic             abort,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             m_last,
  output logic             m_abort,
  input  logic             m_ready,
  output logic             busy,
  output logic             err_oversize,
  output logic [CNT_W-1:0] frame_cnt
);

  state_t           state, state_n;
  logic [LEN_W-1:0] len, len_n, len_inc;
  logic             slot_free, load, load_last, load_abort, crc_rst, oversize;
  logic [7:0]       load_data;
  logic [15:0]      crc_inv;
  logic             crc_ok_unused;

  crc16_8 u_crc (
    .clk     (clk),
    .reset   (reset),
    .d       (s_data),
    .en      (s_valid && s_ready),
    .crc_rst (crc_rst),
    .crc_inv (crc_inv),
    .crc_ok  (crc_ok_unused)
  );

  assign slot_free = !m_valid || m_ready;
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_n    = state;
    len_n      = len;
    s_ready    = 1'b0;
    load       = 1'b0;
    load_data  = m_data;
    load_last  = 1'b0;
    load_abort = 1'b0;
    crc_rst    = 1'b0;
    oversize   = 1'b0;
    len_inc    = (state == S_IDLE) ? LEN_W'(1) : len + LEN_W'(1);
    unique case (state)
      S_IDLE, S_DATA: begin
        // abort wins over a same-cycle byte, but only once a frame is under way
        s_ready = slot_free && !(abort && state == S_DATA);
        if (state == S_DATA && abort) begin
          state_n = S_ABT;
        end else if (s_valid && s_ready) begin
          load      = 1'b1;
          load_data = s_data;
          len_n     = len_inc;
          if (s_last)                          state_n = S_FCS_LO;
          else if (len_inc == LEN_W'(MAX_LEN)) begin
            state_n  = S_ABT;
            oversize = 1'b1;
          end else                             state_n = S_DATA;
        end
      end
      S_FCS_LO: if (slot_free) begin
        load      = 1'b1;
        load_data = crc_inv[7:0];
        state_n   = S_FCS_HI;
      end
      S_FCS_HI: if (slot_free) begin
        load      = 1'b1;
        load_data = crc_inv[15:8];
        load_last = 1'b1;
        crc_rst   = 1'b1;
        len_n     = '0;
        state_n   = S_IDLE;
      end
      S_ABT: if (slot_free) begin
        load       = 1'b1;
        load_data  = HDLC_ABORT_BYTE;
        load_last  = 1'b1;
        load_abort = 1'b1;
        crc_rst    = 1'b1;
        len_n      = '0;
        state_n    = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Output register stage: holds its byte until the downstream handshake
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      len          <= '0;
      m_valid      <= 1'b0;
      m_data       <= 8'h00;
      m_last       <= 1'b0;
      m_abort      <= 1'b0;
      err_oversize <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      state        <= state_n;
      len          <= len_n;
      err_oversize <= oversize;
      if (load) begin
        m_valid <= 1'b1;
        m_data  <= load_data;
        m_last  <= load_last;
        m_abort <= load_abort;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
      if (m_valid && m_ready && m_last && !m_abort) frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hdlc_fcs_sequencer.sv
// Bench for hdlc_fcs_sequencer: table frames, abort/oversize/reset sequences, random frames vs model.
module tb_hdlc_fcs_sequencer;

  typedef struct packed {logic [7:0] d; logic last; logic abt;} obyte_t;
  typedef struct {int len; logic [7:0] b[9]; logic [15:0] fcs; bit stall; bit gaps;} vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, s_valid, s_last, s_ready, abort, m_valid, m_last, m_abort, m_ready, busy, err_oversize;
  logic [7:0]  s_data, m_data;
  logic [15:0] frame_cnt;
  logic        b_s_valid, b_s_last, b_s_ready, b_abort, b_m_valid, b_m_last, b_m_abort, b_m_ready, b_busy, b_err;
  logic [7:0]  b_s_data, b_m_data;
  logic [15:0] b_frame_cnt;
  logic        chk_reset, chk_ok;
  logic [15:0] chk_inv;

  hdlc_fcs_sequencer dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .abort(abort), .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_abort(m_abort),
    .m_ready(m_ready), .busy(busy), .err_oversize(err_oversize), .frame_cnt(frame_cnt));

  hdlc_fcs_sequencer #(.MAX_LEN(4), .LEN_W(3), .CNT_W(16)) dut_small (
    .clk(clk), .reset(reset), .s_data(b_s_data), .s_valid(b_s_valid), .s_last(b_s_last), .s_ready(b_s_ready),
    .abort(b_abort), .m_data(b_m_data), .m_valid(b_m_valid), .m_last(b_m_last), .m_abort(b_m_abort),
    .m_ready(b_m_ready), .busy(b_busy), .err_oversize(b_err), .frame_cnt(b_frame_cnt));

  crc16_8 u_chk (
    .clk(clk), .reset(chk_reset), .d(m_data), .en(m_valid && m_ready), .crc_rst(1'b0),
    .crc_inv(chk_inv), .crc_ok(chk_ok));

  obyte_t out_q[$], exp_q[$], outb_q[$];
  int     out_cyc[$];
  int     cyc = 0, n_tests = 0, n_fail = 0, exp_cnt = 0, a_err_cnt = 0, b_err_cnt = 0;
  bit     stall_en = 1'b0, gap_en = 1'b0, hold_pend = 1'b0;
  obyte_t held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!reset && m_valid && m_ready) begin
      out_q.push_back({m_data, m_last, m_abort});
      out_cyc.push_back(cyc);
    end
    if (!reset && b_m_valid && b_m_ready) outb_q.push_back({b_m_data, b_m_last, b_m_abort});
    if (err_oversize) a_err_cnt++;
    if (b_err) b_err_cnt++;
  end

  // Stalled output must not change until it is taken
  always @(negedge clk) begin
    if (hold_pend && !reset) begin
      check("hold_valid", 32'(m_valid), 32'd1);
      check("hold_data", 32'({m_data, m_last, m_abort}), 32'(held));
    end
    hold_pend = m_valid && !m_ready && !reset;
    held      = {m_data, m_last, m_abort};
  end

  // X.25 FCS from the bit-level definition: MSB-first CRC over bit-reversed input, result reflected and inverted
  function automatic logic [15:0] fcs_model(input logic [7:0] pl[$]);
    logic [15:0] c, r;
    logic        fb;
    c = 16'hFFFF;
    foreach (pl[k])
      for (int i = 0; i < 8; i++) begin
        fb = c[15] ^ pl[k][i];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    for (int i = 0; i < 16; i++) r[i] = c[15-i];
    return ~r;
  endfunction

  task automatic push_frame(input logic [7:0] pl[$], input logic [15:0] fcs);
    foreach (pl[k]) exp_q.push_back({pl[k], 1'b0, 1'b0});
    exp_q.push_back({fcs[7:0], 1'b0, 1'b0});
    exp_q.push_back({fcs[15:8], 1'b1, 1'b0});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    m_ready = stall_en ? ($urandom_range(0, 1) != 0) : 1'b1;
  endtask

  task automatic drive_frame(input logic [7:0] pl[$], input int abort_after);
    int idx = 0;
    int guard = 0;
    bit acc;
    while (idx < pl.size()) begin
      s_data  = pl[idx];
      s_last  = (idx == pl.size() - 1);
      s_valid = gap_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      acc = s_valid && s_ready;
      tick();
      if (acc) idx++;
      if (abort_after > 0 && idx == abort_after) begin
        s_valid = 1'b0; s_last = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        return;
      end
      guard++;
      if (guard > 3000) begin
        check("drive_timeout", 32'(idx), 32'(pl.size()));
        break;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic compare_out(input string tag, input int span_len);
    int guard = 0;
    while (out_q.size() < exp_q.size() && guard < 3000) begin
      tick();
      guard++;
    end
    repeat (4) tick();
    check({tag, "_count"}, 32'(out_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i])
      if (i < out_q.size()) check($sformatf("%s_byte%0d", tag, i), 32'(out_q[i]), 32'(exp_q[i]));
    if (span_len > 0 && out_q.size() == exp_q.size())
      check({tag, "_span"}, 32'(out_cyc[out_cyc.size()-1] - out_cyc[0]), 32'(span_len + 1));
    out_q.delete(); out_cyc.delete(); exp_q.delete();
  endtask

  task automatic pulse_chk();
    chk_reset = 1'b1;
    #1;
    chk_reset = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vt[5];
    logic [7:0]  pl[$];
    logic [7:0]  digits[$];
    logic [15:0] fcs;
    int          len, k, idx, guard;
    bit          acc;

    digits = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    vt[0].len = 9; vt[0].b = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    vt[0].fcs = 16'h906E; vt[0].stall = 0; vt[0].gaps = 0;
    vt[1].len = 1; vt[1].b = '{default: 8'h00}; vt[1].fcs = 16'hF078; vt[1].stall = 0; vt[1].gaps = 0;
    vt[2].len = 1; vt[2].b = '{default: 8'hFF}; vt[2].fcs = 16'hFF00; vt[2].stall = 0; vt[2].gaps = 0;
    vt[3] = vt[0]; vt[3].stall = 1;
    vt[4] = vt[0]; vt[4].stall = 1; vt[4].gaps = 1;

    reset = 1'b1; chk_reset = 1'b1; m_ready = 1'b1; abort = 1'b0;
    s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00;
    b_s_valid = 1'b0; b_s_last = 1'b0; b_s_data = 8'h00; b_abort = 1'b0; b_m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_last", 32'(m_last), 0);
    check("rst_m_abort", 32'(m_abort), 0);
    check("rst_m_data", 32'(m_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_err", 32'(err_oversize), 0);
    check("rst_frame_cnt", 32'(frame_cnt), 0);
    reset = 1'b0; chk_reset = 1'b0;
    tick();
    check("idle_s_ready", 32'(s_ready), 1);

    for (int v = 0; v < 5; v++) begin
      pulse_chk();
      stall_en = vt[v].stall; gap_en = vt[v].gaps;
      pl.delete();
      for (int i = 0; i < vt[v].len; i++) pl.push_back(vt[v].b[i]);
      push_frame(pl, vt[v].fcs);
      drive_frame(pl, 0);
      exp_cnt++;
      compare_out($sformatf("vec%0d", v), (vt[v].stall || vt[v].gaps) ? 0 : vt[v].len);
      check($sformatf("vec%0d_cnt", v), 32'(frame_cnt), 32'(exp_cnt));
      check($sformatf("vec%0d_residue", v), 32'(chk_ok), 1);
      check($sformatf("vec%0d_busy", v), 32'(busy), 0);
    end
    stall_en = 0; gap_en = 0;

    // abort after 3 payload bytes, then a clean frame
    pl = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    for (int i = 0; i < 3; i++) exp_q.push_back({pl[i], 1'b0, 1'b0});
    exp_q.push_back({8'h00, 1'b1, 1'b1});
    drive_frame(pl, 3);
    compare_out("abort3", 0);
    check("abort3_cnt", 32'(frame_cnt), 32'(exp_cnt));
    pulse_chk();
    push_frame(digits, 16'h906E);
    drive_frame(digits, 0);
    exp_cnt++;
    compare_out("after_abort", 9);
    check("after_abort_cnt", 32'(frame_cnt), 32'(exp_cnt));
    check("after_abort_residue", 32'(chk_ok), 1);

    // abort raised during FCS and idle is ignored
    pl = '{8'h5A, 8'hC3};
    push_frame(pl, fcs_model(pl));
    drive_frame(pl, 0);
    abort = 1'b1;
    repeat (4) tick();
    abort = 1'b0;
    exp_cnt++;
    compare_out("abort_late", 0);
    check("abort_late_cnt", 32'(frame_cnt), 32'(exp_cnt));

    for (int f = 0; f < 20; f++) begin
      len = $urandom_range(1, 24);
      pl.delete();
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
      stall_en = ($urandom_range(0, 1) != 0);
      gap_en   = ($urandom_range(0, 1) != 0);
      pulse_chk();
      if (len > 1 && $urandom_range(0, 4) == 0) begin
        k = $urandom_range(1, len - 1);
        for (int i = 0; i < k; i++) exp_q.push_back({pl[i], 1'b0, 1'b0});
        exp_q.push_back({8'h00, 1'b1, 1'b1});
        drive_frame(pl, k);
        compare_out($sformatf("rnd%0d_abt", f), 0);
      end else begin
        push_frame(pl, fcs_model(pl));
        drive_frame(pl, 0);
        exp_cnt++;
        compare_out($sformatf("rnd%0d", f), 0);
        check($sformatf("rnd%0d_residue", f), 32'(chk_ok), 1);
      end
      check($sformatf("rnd%0d_cnt", f), 32'(frame_cnt), 32'(exp_cnt));
    end
    stall_en = 0; gap_en = 0;
    check("no_oversize_default", 32'(a_err_cnt), 0);

    // MAX_LEN=4 instance: 5-byte frame overflows, 5th byte starts a new frame
    pl = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5};
    idx = 0; guard = 0;
    while (idx < 5 && guard < 200) begin
      b_s_data = pl[idx]; b_s_last = (idx == 4); b_s_valid = 1'b1;
      @(negedge clk);
      acc = b_s_valid && b_s_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      guard++;
    end
    b_s_valid = 1'b0; b_s_last = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("ovs_accepted", 32'(idx), 5);
    fcs = fcs_model('{8'hB5});
    exp_q = '{{8'hB1, 1'b0, 1'b0}, {8'hB2, 1'b0, 1'b0}, {8'hB3, 1'b0, 1'b0}, {8'hB4, 1'b0, 1'b0},
              {8'h00, 1'b1, 1'b1}, {8'hB5, 1'b0, 1'b0}, {fcs[7:0], 1'b0, 1'b0}, {fcs[15:8], 1'b1, 1'b0}};
    check("ovs_count", 32'(outb_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) if (i < outb_q.size()) check($sformatf("ovs_byte%0d", i), 32'(outb_q[i]), 32'(exp_q[i]));
    exp_q.delete();
    check("ovs_err_pulses", 32'(b_err_cnt), 1);
    check("ovs_busy", 32'(b_busy), 0);
    check("ovs_frame_cnt", 32'(b_frame_cnt), 1);

    // reset while the FCS high byte is waiting
    for (int i = 0; i < 9; i++) exp_q.push_back({digits[i], 1'b0, 1'b0});
    exp_q.push_back({8'h6E, 1'b0, 1'b0});
    drive_frame(digits, 0);
    guard = 0;
    while (out_q.size() < 10 && guard < 200) begin
      tick();
      guard++;
    end
    reset = 1'b1;
    #1;
    check("rstmid_m_valid", 32'(m_valid), 0);
    check("rstmid_busy", 32'(busy), 0);
    check("rstmid_frame_cnt", 32'(frame_cnt), 0);
    tick();
    reset = 1'b0;
    compare_out("rstmid", 0);
    exp_cnt = 0;
    pulse_chk();
    push_frame(digits, 16'h906E);
    drive_frame(digits, 0);
    exp_cnt++;
    compare_out("post_rst", 9);
    check("post_rst_cnt", 32'(frame_cnt), 32'(exp_cnt));
    check("post_rst_residue", 32'(chk_ok), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
